dma_request_generator: RTL and testbench
========================================

DMA_REQUEST_GENERATOR -- requirements
Module: dma_request_generator

Interface
REQ-001 Parameter NUM_CH, default 4: number of DMA request channels, legal range 1..8.
REQ-002 Parameter DELAY_W, default 8: width of each per-channel start-delay field.
REQ-003 Parameter WIDTH_W, default 4: width of each per-channel pulse-width field.
REQ-004 Port Clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Port Reset  input  1: synchronous, active-low reset.
REQ-006 Port Start  input  1: one-cycle request to launch a burst using the current configuration.
REQ-007 Port ChEnable  input  NUM_CH: per-channel participation mask for the burst.
REQ-008 Port Delay  input  NUM_CH x DELAY_W: per-channel cycles from Start to Dreq assertion.
REQ-009 Port Width  input  NUM_CH x WIDTH_W: per-channel Dreq high time in pulse mode.
REQ-010 Port Handshake  input  NUM_CH: per-channel mode; 0 = fixed pulse, 1 = hold until Dack.
REQ-011 Port Dack  input  NUM_CH: per-channel DMA acknowledge from the controller, active high.
REQ-012 Port nEOP  input  1: end-of-process from the bus, active low.
REQ-013 Port Dreq  output  NUM_CH: per-channel DMA request, active high.
REQ-014 Port Busy  output  1: high while any channel is outside IDLE.
REQ-015 Port Done  output  1: one-cycle pulse when a burst completes or is aborted.

Function
REQ-016 The block SHALL sample Start only when Busy is low; Start while Busy SHALL be ignored, with no effect on state or configuration.
REQ-017 On an accepted Start, ChEnable, Delay, Width and Handshake SHALL be latched; later input changes SHALL not affect the running burst.
REQ-018 Each channel SHALL run the FSM IDLE -> WAIT -> REQ -> FIN, and SHALL return FIN -> IDLE when Done is issued.
REQ-019 A channel with ChEnable=0 at Start SHALL go directly to FIN and SHALL keep Dreq low for the whole burst.
REQ-020 In WAIT, the channel SHALL count Delay cycles; Dreq SHALL be high in the cycle Delay+1 edges after the Start edge (Delay=0 gives Dreq in the first cycle after Start).
REQ-021 In pulse mode, Dreq SHALL stay high for exactly max(Width,1) cycles, and the channel SHALL then enter FIN.
REQ-022 In handshake mode, Dreq SHALL stay high until Dack is sampled high; Dreq SHALL be low in the following cycle, and the channel SHALL enter FIN.
REQ-023 Dack on a channel in pulse mode, or in any state other than REQ, SHALL be ignored.
REQ-024 The delay and width counters SHALL saturate and never wrap; a Delay of all-ones SHALL produce 2^DELAY_W cycles of WAIT without rollover.
REQ-025 While Busy, nEOP sampled low SHALL force every channel to FIN in the next cycle and drop all Dreq in that cycle, regardless of mode.
REQ-026 When all channels are in FIN, Done SHALL be high for exactly one cycle; Busy SHALL go low in the same cycle, and all channels SHALL return to IDLE.
REQ-027 A Start sampled in the cycle that Done is high SHALL be ignored; the earliest accepted restart is the next cycle.
REQ-028 If all channels are disabled, Done SHALL pulse in the second cycle after the Start edge.
REQ-029 Channels SHALL run concurrently and independently; several Dreq bits may be high at once.

Reset
REQ-030 When Reset is low at a rising edge, all channels SHALL go to IDLE, counters and latched configuration SHALL clear to 0, and Dreq, Busy and Done SHALL be 0.
REQ-031 Reset mid-burst SHALL abort without a Done pulse; the first Start after Reset is released SHALL be accepted.

Structure
REQ-032 The channel state enum (IDLE, WAIT, REQ, FIN) and the mode encoding SHALL live in the shared package dreq_gen_pkg.
REQ-033 The per-channel FSM and counters SHALL be the sub-module dreq_channel_fsm, instantiated NUM_CH times via generate.
REQ-034 The top level SHALL contain only Start acceptance, configuration latching, nEOP abort fan-out, and Busy/Done aggregation.

Verification
REQ-035 NUM_CH=4, ChEnable=0001, Delay0=0, Width0=2, pulse mode -> Dreq[0] high in cycles 1-2 after Start, Done in cycle 4.
REQ-036 ChEnable=1111, Delays 3/0/5/1, Width=1 for all -> each Dreq rises Delay+1 edges after Start, independently; one Done after the last channel.
REQ-037 Ch2 in handshake mode, Delay=0; Dack asserted 6 cycles later -> Dreq[2] high for 6 cycles, low the next cycle, then Done.
REQ-038 nEOP driven low while Dreq=1010 -> Dreq=0000 on the next cycle, then a single Done; Start during Busy produces no second burst.
REQ-039 Reset low during WAIT -> outputs 0, no Done; Start after release with Delay=255, DELAY_W=8 -> Dreq rises after 256 cycles.

Source files
------------

// File: rtl/dreq_gen_pkg.sv
// Shared types for the DMA request generator: channel state, mode encoding
// and the per-channel control bundle driven by the top level.
package dreq_gen_pkg;

  // Per-channel sequencing state
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_REQ  = 2'd2,
    CH_FIN  = 2'd3
  } ch_state_e;

  // Request termination mode
  typedef enum logic {
    MODE_PULSE     = 1'b0,
    MODE_HANDSHAKE = 1'b1
  } ch_mode_e;

  // Burst-level control fanned out from the top to every channel
  typedef struct packed {
    logic launch;   // accepted Start this cycle
    logic enable;   // channel participates in the burst being launched
    logic abort;    // nEOP seen while busy
    logic retire;   // Done issued: every channel back to IDLE
  } ch_ctrl_t;

endpackage

// File: rtl/dreq_channel_fsm.sv
// One DMA request channel: start delay, then a fixed-width pulse or a
// request held until acknowledge. Counters saturate instead of wrapping.
module dreq_channel_fsm
  import dreq_gen_pkg::*;
#(
  parameter int unsigned DELAY_W = 8,
  parameter int unsigned WIDTH_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ch_ctrl_t           ctrl,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  ch_mode_e           mode,
  input  logic               dack,
  output ch_state_e          state,
  output logic               dreq
);

  localparam logic [DELAY_W-1:0] DLY_MAX = '1;
  localparam logic [WIDTH_W-1:0] WID_MAX = '1;

  ch_state_e          state_nx;
  logic [DELAY_W-1:0] dly_q;
  logic [DELAY_W-1:0] dly_nx;
  logic [WIDTH_W-1:0] wid_q;
  logic [WIDTH_W-1:0] wid_nx;

  // State, counters and the registered request output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CH_IDLE;
      dly_q <= '0;
      wid_q <= '0;
      dreq  <= 1'b0;
    end else begin
      state <= state_nx;
      dly_q <= dly_nx;
      wid_q <= wid_nx;
      dreq  <= (state_nx == CH_REQ);
    end
  end

  // Next state: retire beats abort beats normal sequencing
  always_comb begin
    state_nx = state;
    dly_nx   = dly_q;
    wid_nx   = wid_q;
    if (ctrl.retire) begin
      state_nx = CH_IDLE;
      dly_nx   = '0;
      wid_nx   = '0;
    end else if (ctrl.abort && (state != CH_IDLE)) begin
      state_nx = CH_FIN;
    end else begin
      case (state)
        CH_IDLE: begin
          if (ctrl.launch) begin
            state_nx = ctrl.enable ? CH_WAIT : CH_FIN;
            dly_nx   = '0;
            wid_nx   = '0;
          end
        end
        CH_WAIT: begin
          // dly_q counts completed WAIT cycles; delay+1 cycles in total
          if (dly_q == delay) begin
            state_nx = CH_REQ;
            wid_nx   = WIDTH_W'(1);
          end else if (dly_q != DLY_MAX) begin
            dly_nx = dly_q + DELAY_W'(1);
          end
        end
        CH_REQ: begin
          if (mode == MODE_HANDSHAKE) begin
            if (dack) begin
              state_nx = CH_FIN;
            end
          end else if (wid_q >= width) begin
            // width of 0 behaves as 1: wid_q starts at 1
            state_nx = CH_FIN;
          end else if (wid_q != WID_MAX) begin
            wid_nx = wid_q + WIDTH_W'(1);
          end
        end
        CH_FIN: begin
          state_nx = CH_FIN;
        end
        default: begin
          state_nx = CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_request_generator.sv
// Multi-channel DMA request generator: accepts a burst launch, latches the
// per-channel configuration, fans out nEOP abort and aggregates completion.
module dma_request_generator
  import dreq_gen_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DELAY_W = 8,
  parameter int unsigned WIDTH_W = 4
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic [NUM_CH-1:0]               ChEnable,
  input  logic [NUM_CH-1:0][DELAY_W-1:0]  Delay,
  input  logic [NUM_CH-1:0][WIDTH_W-1:0]  Width,
  input  logic [NUM_CH-1:0]               Handshake,
  input  logic [NUM_CH-1:0]               Dack,
  input  logic                            nEOP,
  output logic [NUM_CH-1:0]               Dreq,
  output logic                            Busy,
  output logic                            Done
);

  logic [NUM_CH-1:0][DELAY_W-1:0] delay_q;
  logic [NUM_CH-1:0][WIDTH_W-1:0] width_q;
  logic [NUM_CH-1:0]              mode_q;
  logic                           launch_q;

  logic                           accept_c;
  logic                           abort_c;
  logic                           retire_c;
  logic                           all_fin_c;
  logic [NUM_CH-1:0]              fin_c;
  ch_state_e                      ch_state [NUM_CH];

  // Start is only honoured when idle and not in the Done cycle
  assign accept_c = Start && !Busy && !Done;
  assign abort_c  = Busy && !nEOP;

  // Completion detect; the launch cycle is excluded so an all-disabled
  // burst still spends one full cycle in FIN before Done
  always_comb begin
    fin_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fin_c[i] = (ch_state[i] == CH_FIN);
    end
  end

  assign all_fin_c = &fin_c;
  assign retire_c  = Busy && all_fin_c && !launch_q;

  // Burst status and configuration captured on acceptance
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      delay_q  <= '0;
      width_q  <= '0;
      mode_q   <= '0;
      launch_q <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      launch_q <= accept_c;
      Done     <= retire_c;
      if (accept_c) begin
        Busy    <= 1'b1;
        delay_q <= Delay;
        width_q <= Width;
        mode_q  <= Handshake;
      end else if (retire_c) begin
        Busy <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    ch_ctrl_t ctrl_c;

    assign ctrl_c = '{launch: accept_c, enable: ChEnable[i],
                      abort: abort_c, retire: retire_c};

    dreq_channel_fsm #(
      .DELAY_W (DELAY_W),
      .WIDTH_W (WIDTH_W)
    ) u_ch (
      .clk   (Clock),
      .rst_n (Reset),
      .ctrl  (ctrl_c),
      .delay (delay_q[i]),
      .width (width_q[i]),
      .mode  (ch_mode_e'(mode_q[i])),
      .dack  (Dack[i]),
      .state (ch_state[i]),
      .dreq  (Dreq[i])
    );
  end

endmodule

// File: tb/tb_dma_request_generator.sv
// Scoreboard bench for dma_request_generator: a cycle model fills a queue of
// expected {Dreq, Busy, Done} per cycle at launch; each cycle pops one entry.
module tb_dma_request_generator;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DELAY_W = 8;
  localparam int unsigned WIDTH_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           rst_n;
  logic                           start;
  logic                           neop;
  logic [NUM_CH-1:0]              ch_enable;
  logic [NUM_CH-1:0]              handshake;
  logic [NUM_CH-1:0]              dack;
  logic [NUM_CH-1:0][DELAY_W-1:0] delay_in;
  logic [NUM_CH-1:0][WIDTH_W-1:0] width_in;
  logic [NUM_CH-1:0]              dreq;
  logic                           busy;
  logic                           done;

  dma_request_generator #(
    .NUM_CH  (NUM_CH),
    .DELAY_W (DELAY_W),
    .WIDTH_W (WIDTH_W)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Start     (start),
    .ChEnable  (ch_enable),
    .Delay     (delay_in),
    .Width     (width_in),
    .Handshake (handshake),
    .Dack      (dack),
    .nEOP      (neop),
    .Dreq      (dreq),
    .Busy      (busy),
    .Done      (done)
  );

  // Burst configuration seen by the model (ports get scrambled mid-burst)
  logic [3:0] g_en;
  logic [3:0] g_hs;
  logic [7:0] g_delay [4];
  logic [3:0] g_width [4];
  int         g_dack [4];
  int         g_dack_early [4];
  int         g_abort;
  int         g_restart;

  logic [5:0] exp_q [$];
  int checks = 0;
  int passed = 0;

  task automatic clear_cfg();
    g_en = '0;
    g_hs = '0;
    for (int i = 0; i < 4; i++) begin
      g_delay[i]      = '0;
      g_width[i]      = '0;
      g_dack[i]       = -1;
      g_dack_early[i] = -1;
    end
    g_abort   = -1;
    g_restart = -1;
  endtask

  // Cycle k is the cycle following the k-th edge after the Start edge (k=0)
  task automatic fill_model(input int n);
    int  done_c;
    int  rise [4];
    int  fin [4];
    bit  ab_ok;
    logic [3:0] dr;
    done_c = 2;
    for (int i = 0; i < 4; i++) begin
      rise[i] = int'(g_delay[i]) + 1;
      if (g_hs[i]) fin[i] = g_dack[i] + 1;
      else         fin[i] = rise[i] + ((g_width[i] == 4'd0) ? 1 : int'(g_width[i]));
      if (g_en[i] && (fin[i] + 1 > done_c)) done_c = fin[i] + 1;
    end
    ab_ok = (g_abort >= 0) && (g_abort < done_c);
    if (ab_ok && (g_abort + 2 < done_c)) done_c = g_abort + 2;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        dr[i] = g_en[i] && (k >= rise[i]) && (k < fin[i]) && !(ab_ok && (k >= g_abort + 1));
      end
      exp_q.push_back({dr, (k < done_c), (k == done_c)});
    end
  endtask

  task automatic apply_cfg();
    ch_enable = g_en;
    handshake = g_hs;
    for (int i = 0; i < 4; i++) begin
      delay_in[i] = g_delay[i];
      width_in[i] = g_width[i];
    end
  endtask

  task automatic launch();
    @(negedge clk);
    apply_cfg();
    start = 1'b1;
    neop  = 1'b1;
    dack  = '0;
  endtask

  // Inputs for cycle k (sampled at the edge ending it); config ports randomised
  task automatic drive_cycle(input int k);
    start = (k == g_restart);
    neop  = (k != g_abort);
    for (int i = 0; i < 4; i++) begin
      dack[i] = (k == g_dack[i]) || (k == g_dack_early[i]);
    end
    ch_enable = 4'($urandom);
    handshake = 4'($urandom);
    delay_in  = 32'($urandom);
    width_in  = 16'($urandom);
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done};
      checks++;
      if (obs !== 6'b0) $display("FAIL reset cycle %0d: got %b expected 000000", k, obs);
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b0001; g_width[0] = 4'd2;
    g_dack_early[0] = 1;
    fill_model(6);
    launch();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL single_pulse cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_concurrent();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b1111;
    g_delay[0] = 8'd3; g_delay[1] = 8'd0; g_delay[2] = 8'd5; g_delay[3] = 8'd1;
    for (int i = 0; i < 4; i++) g_width[i] = 4'd1;
    fill_model(10);
    launch();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL concurrent cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_handshake();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b0100; g_hs = 4'b0100; g_width[2] = 4'd1;
    g_dack_early[2] = 0;
    g_dack[2] = 6;
    fill_model(10);
    launch();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL handshake cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_mixed_modes();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b0011; g_hs = 4'b0010;
    g_delay[0] = 8'd2; g_width[0] = 4'd0;
    g_delay[1] = 8'd1; g_dack_early[1] = 1; g_dack[1] = 5;
    fill_model(9);
    launch();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL mixed_modes cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_abort();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b1010;
    g_delay[1] = 8'd0; g_width[1] = 4'd10;
    g_delay[3] = 8'd2; g_width[3] = 4'd10;
    g_abort = 4;
    g_restart = 2;
    fill_model(12);
    launch();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL abort cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_all_disabled();
    logic [5:0] obs, expv;
    clear_cfg();
    g_delay[0] = 8'd7; g_width[0] = 4'd3;
    fill_model(4);
    launch();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL all_disabled cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, expv;
    // Burst A finishes with Done in cycle 4; Start is held from that cycle on
    clear_cfg();
    g_en = 4'b0001; g_width[0] = 4'd2;
    g_restart = 4;
    fill_model(5);
    launch();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL back_to_back_a cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
    @(negedge clk);
    obs = {dreq, busy, done}; checks++;
    if (obs !== 6'b0) $display("FAIL start_in_done_cycle: got %b expected 000000", obs);
    else passed++;
    clear_cfg();
    g_en = 4'b0110;
    g_delay[1] = 8'd1; g_width[1] = 4'd3;
    g_delay[2] = 8'd0; g_width[2] = 4'd0;
    fill_model(8);
    apply_cfg();
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL back_to_back_b cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] obs, expv;
    clear_cfg();
    g_en = 4'b0001; g_delay[0] = 8'd20; g_width[0] = 4'd1;
    fill_model(6);
    launch();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL pre_reset cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
      if (k == 5) rst_n = 1'b0;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; checks++;
      if (obs !== 6'b0) $display("FAIL reset_abort cycle %0d: got %b expected 000000", j, obs);
      else passed++;
      if (j == 1) begin
        rst_n = 1'b1;
        start = 1'b0;
        neop  = 1'b1;
        dack  = '0;
      end
    end
    // Long saturating delay: Dreq rises 256 edges after Start
    clear_cfg();
    g_en = 4'b0001; g_delay[0] = 8'd255; g_width[0] = 4'd1;
    fill_model(260);
    launch();
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      obs = {dreq, busy, done}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) $display("FAIL long_delay cycle %0d: got dreq=%b busy=%b done=%b expected dreq=%b busy=%b done=%b", k, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
      else passed++;
      drive_cycle(k);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    neop      = 1'b1;
    dack      = '0;
    ch_enable = '0;
    handshake = '0;
    delay_in  = '0;
    width_in  = '0;
    clear_cfg();
    test_reset();
    test_single_pulse();
    test_concurrent();
    test_handshake();
    test_mixed_modes();
    test_abort();
    test_all_disabled();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
